// File: rtl/l1_d_pkg.sv
// Shared op encodings, FSM states and default geometry for the L1 D-cache data array.
package l1_d_pkg;

  localparam int unsigned DEF_NUM_WAYS   = 2;
  localparam int unsigned DEF_NUM_SETS   = 64;
  localparam int unsigned DEF_BLOCK_BITS = 512;
  localparam int unsigned DEF_WORD_BITS  = 32;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_REFILL  = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_REPL_WR = 1'b1
  } state_e;

endpackage

// File: rtl/l1_d_data_way.sv
// One way of the data array: NUM_SETS blocks with whole-block write and byte-strobed word write.
module l1_d_data_way #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned BLOCK_BITS = 512,
  parameter int unsigned WORD_BITS  = 32,
  localparam int unsigned IDX_W     = $clog2(NUM_SETS),
  localparam int unsigned WSEL_W    = $clog2(BLOCK_BITS / WORD_BITS),
  localparam int unsigned STRB_W    = WORD_BITS / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic                  blk_we,
  input  logic [BLOCK_BITS-1:0] blk_wdata,
  input  logic                  word_we,
  input  logic [WSEL_W-1:0]     word_sel,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [WORD_BITS-1:0]  wdata,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [BLOCK_BITS-1:0] rd_block
);

  logic [BLOCK_BITS-1:0] mem_q [NUM_SETS];
  logic [BLOCK_BITS-1:0] mem_d [NUM_SETS];

  // Next array contents: block write wins over a strobed word write.
  always_comb begin
    mem_d = mem_q;
    if (blk_we) begin
      mem_d[wr_index] = blk_wdata;
    end else if (word_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) begin
          mem_d[wr_index][32'(word_sel) * WORD_BITS + 32'(b) * 8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  // Storage flops, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        mem_q[s] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_block = mem_q[rd_index];

endmodule

// File: rtl/l1_d_data_array_assoc.sv
// N-way set-associative L1 D-cache data store with read, strobed write, refill and atomic replace.
module l1_d_data_array_assoc
  import l1_d_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
  parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
  parameter int unsigned BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int unsigned WORD_BITS  = DEF_WORD_BITS,
  localparam int unsigned IDX_W     = $clog2(NUM_SETS),
  localparam int unsigned OFF_W     = $clog2(BLOCK_BITS / 8),
  localparam int unsigned WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned STRB_W    = WORD_BITS / 8,
  localparam int unsigned WSEL_W    = $clog2(BLOCK_BITS / WORD_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [IDX_W-1:0]      index,
  input  logic [OFF_W-1:0]      offset,
  input  logic [WAY_W-1:0]      way,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [WORD_BITS-1:0]  write_data,
  input  logic [BLOCK_BITS-1:0] refill_data,
  output logic                  rd_valid,
  output logic [WORD_BITS-1:0]  read_data,
  output logic                  evict_valid,
  output logic [BLOCK_BITS-1:0] evict_data
);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WORD_BITS-1:0]  read_data_q, read_data_d;
  logic                  evict_valid_q, evict_valid_d;
  logic [BLOCK_BITS-1:0] evict_data_q, evict_data_d;
  logic [IDX_W-1:0]      repl_index_q, repl_index_d;
  logic [WAY_W-1:0]      repl_way_q, repl_way_d;
  logic [BLOCK_BITS-1:0] repl_data_q, repl_data_d;

  logic                  blk_we_c, word_we_c;
  logic [IDX_W-1:0]      wr_index_c;
  logic [WAY_W-1:0]      wr_way_c;
  logic [BLOCK_BITS-1:0] blk_wdata_c;
  logic [BLOCK_BITS-1:0] sel_block_c;
  logic [WSEL_W-1:0]     word_sel;
  logic [BLOCK_BITS-1:0] way_blk [NUM_WAYS];
  logic                  unused_offset_lsb;

  assign word_sel          = offset[OFF_W-1:2];
  assign unused_offset_lsb = ^offset[1:0];

  // Per-way storage; only the decoded way sees a write enable.
  for (genvar w = 0; w < int'(NUM_WAYS); w++) begin : g_way
    l1_d_data_way #(
      .NUM_SETS  (NUM_SETS),
      .BLOCK_BITS(BLOCK_BITS),
      .WORD_BITS (WORD_BITS)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .wr_index (wr_index_c),
      .blk_we   (blk_we_c && (wr_way_c == WAY_W'(w))),
      .blk_wdata(blk_wdata_c),
      .word_we  (word_we_c && (wr_way_c == WAY_W'(w))),
      .word_sel (word_sel),
      .wstrb    (wstrb),
      .wdata    (write_data),
      .rd_index (index),
      .rd_block (way_blk[w])
    );
  end

  // Way mux for read/evict; an out-of-range way selects zero.
  always_comb begin
    sel_block_c = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (way == WAY_W'(w)) sel_block_c = way_blk[w];
    end
  end

  // Next-state, write-port steering and output register inputs.
  always_comb begin
    state_d       = state_q;
    rd_valid_d    = 1'b0;
    read_data_d   = read_data_q;
    evict_valid_d = 1'b0;
    evict_data_d  = evict_data_q;
    repl_index_d  = repl_index_q;
    repl_way_d    = repl_way_q;
    repl_data_d   = repl_data_q;
    blk_we_c      = 1'b0;
    word_we_c     = 1'b0;
    wr_index_c    = index;
    wr_way_c      = way;
    blk_wdata_c   = refill_data;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (op_e'(req_op))
            OP_READ: begin
              rd_valid_d  = 1'b1;
              read_data_d = sel_block_c[32'(word_sel) * WORD_BITS +: WORD_BITS];
            end
            OP_WRITE:  word_we_c = 1'b1;
            OP_REFILL: blk_we_c  = 1'b1;
            OP_REPLACE: begin
              evict_valid_d = 1'b1;
              evict_data_d  = sel_block_c;
              repl_index_d  = index;
              repl_way_d    = way;
              repl_data_d   = refill_data;
              state_d       = ST_REPL_WR;
            end
          endcase
        end
      end
      ST_REPL_WR: begin
        blk_we_c    = 1'b1;
        wr_index_c  = repl_index_q;
        wr_way_c    = repl_way_q;
        blk_wdata_c = repl_data_q;
        state_d     = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      rd_valid_q    <= 1'b0;
      read_data_q   <= '0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      repl_index_q  <= '0;
      repl_way_q    <= '0;
      repl_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rd_valid_q    <= rd_valid_d;
      read_data_q   <= read_data_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
      repl_index_q  <= repl_index_d;
      repl_way_q    <= repl_way_d;
      repl_data_q   <= repl_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rd_valid    = rd_valid_q;
  assign read_data   = read_data_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_l1_d_data_array_assoc.sv
// Directed bench for l1_d_data_array_assoc: vector table plus replace/reset sequences.
module tb_l1_d_data_array_assoc;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, RF = 2'b10, RP = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [5:0]   index;
  logic [5:0]   offset;
  logic [0:0]   way;
  logic [3:0]   wstrb;
  logic [31:0]  write_data;
  logic [511:0] refill_data;
  logic         rd_valid;
  logic [31:0]  read_data;
  logic         evict_valid;
  logic [511:0] evict_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_d_data_array_assoc #(
    .NUM_WAYS(2), .NUM_SETS(64), .BLOCK_BITS(512), .WORD_BITS(32)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .index(index), .offset(offset), .way(way), .wstrb(wstrb),
    .write_data(write_data), .refill_data(refill_data), .rd_valid(rd_valid),
    .read_data(read_data), .evict_valid(evict_valid), .evict_data(evict_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  idx;
    logic [5:0]  off;
    logic        w;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] pat_a();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = 32'hA000 + 32'(k);
    return b;
  endfunction

  function automatic logic [511:0] pat_sw(input int w, input int s);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = 32'hC000_0000 + 32'(w) * 32'h1_0000 + 32'(s) * 32'h100 + 32'(k);
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic drive(input logic [1:0] op, input logic [5:0] idx, input logic [5:0] off,
                       input logic w, input logic [3:0] strb, input logic [31:0] wd,
                       input logic [511:0] blk);
    int n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", n);
    end
    req_valid = 1'b1; req_op = op; index = idx; offset = off; way = w;
    wstrb = strb; write_data = wd; refill_data = blk;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] blk;
    rst = 1'b1; req_valid = 1'b0; req_op = RD; index = '0; offset = '0; way = '0;
    wstrb = '0; write_data = '0; refill_data = '0;

    vecs[0]  = '{RF, 6'd5,  6'h00, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[1]  = '{RD, 6'd5,  6'h0C, 1'b1, 4'b0000, 32'h0,        32'h0000_A003};
    vecs[2]  = '{RD, 6'd5,  6'h0C, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{RD, 6'd5,  6'h3C, 1'b1, 4'b0000, 32'h0,        32'h0000_A00F};
    vecs[4]  = '{WR, 6'd5,  6'h0C, 1'b1, 4'b0101, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{RD, 6'd5,  6'h0C, 1'b1, 4'b0000, 32'h0,        32'h00AD_A0EF};
    vecs[6]  = '{WR, 6'd5,  6'h0C, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{RD, 6'd5,  6'h0D, 1'b1, 4'b0000, 32'h0,        32'h00AD_A0EF};
    vecs[8]  = '{WR, 6'd5,  6'h10, 1'b1, 4'b1111, 32'h12345678, 32'h0};
    vecs[9]  = '{RD, 6'd5,  6'h10, 1'b1, 4'b0000, 32'h0,        32'h1234_5678};
    vecs[10] = '{RD, 6'd5,  6'h14, 1'b1, 4'b0000, 32'h0,        32'h0000_A005};
    vecs[11] = '{WR, 6'd5,  6'h00, 1'b0, 4'b1000, 32'hAABBCCDD, 32'h0};
    vecs[12] = '{RD, 6'd5,  6'h00, 1'b0, 4'b0000, 32'h0,        32'hAA00_0000};
    vecs[13] = '{RD, 6'd5,  6'h00, 1'b1, 4'b0000, 32'h0,        32'h0000_A000};
    vecs[14] = '{RD, 6'd63, 6'h3C, 1'b1, 4'b0000, 32'h0,        32'h0};

    // Reset, dirty one block, then reset again mid-idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(RF, 6'd3, 6'h00, 1'b0, 4'b0, 32'h0, pat_a());
    drive(RD, 6'd3, 6'h00, 1'b0, 4'b0, 32'h0, '0);
    check("pre_reset_read", 512'(read_data), 512'(32'h0000_A000));
    rst = 1'b1;
    #1;
    check("rst_read_data",   512'(read_data),   '0);
    check("rst_rd_valid",    512'(rd_valid),    '0);
    check("rst_evict_valid", 512'(evict_valid), '0);
    check("rst_evict_data",  evict_data,        '0);
    check("rst_req_ready",   512'(req_ready),   512'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(RD, 6'd3, 6'h00, 1'b0, 4'b0, 32'h0, '0);
    check("rst_cleared_read", 512'(read_data), '0);
    check("rst_read_valid",   512'(rd_valid),  512'(1));

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].idx, vecs[i].off, vecs[i].w, vecs[i].strb, vecs[i].wdata, pat_a());
      if (vecs[i].op == RD) begin
        check($sformatf("vec%0d_rd_valid", i), 512'(rd_valid), 512'(1));
        check($sformatf("vec%0d_data", i), 512'(read_data), 512'(vecs[i].exp));
      end else begin
        check($sformatf("vec%0d_no_rd_valid", i), 512'(rd_valid), '0);
      end
    end

    // Replace idx5 way1: victim out at T+1, new block visible afterwards.
    blk = {16{32'h5A5A5A5A}};
    drive(RP, 6'd5, 6'h00, 1'b1, 4'b0, 32'h0, blk);
    check("repl_evict_valid", 512'(evict_valid), 512'(1));
    check("repl_word3", 512'(evict_data[3*32 +: 32]), 512'(32'h00AD_A0EF));
    check("repl_word4", 512'(evict_data[4*32 +: 32]), 512'(32'h1234_5678));
    check("repl_word0", 512'(evict_data[0 +: 32]),     512'(32'h0000_A000));
    check("repl_ready_low", 512'(req_ready), '0);
    check("repl_no_rd_valid", 512'(rd_valid), '0);
    @(negedge clk);
    check("repl_evict_pulse", 512'(evict_valid), '0);
    check("repl_ready_back", 512'(req_ready), 512'(1));
    drive(RD, 6'd5, 6'h08, 1'b1, 4'b0, 32'h0, '0);
    check("repl_new_data", 512'(read_data), 512'(32'h5A5A5A5A));
    drive(RD, 6'd5, 6'h00, 1'b0, 4'b0, 32'h0, '0);
    check("repl_other_way", 512'(read_data), 512'(32'hAA00_0000));

    // Refill every set/way back-to-back, then read all back every cycle.
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 2; w++)
        drive(RF, 6'(s), 6'h00, 1'(w), 4'b0, 32'h0, pat_sw(w, s));
    for (int i = 0; i < 128; i++) begin
      int s = i / 2;
      int w = i % 2;
      int k = s % 16;
      drive(RD, 6'(s), 6'(k * 4), 1'(w), 4'b0, 32'h0, '0);
      blk = pat_sw(w, s);
      check($sformatf("b2b_valid_s%0d_w%0d", s, w), 512'(rd_valid), 512'(1));
      check($sformatf("b2b_data_s%0d_w%0d", s, w), 512'(read_data), 512'(blk[k*32 +: 32]));
    end

    // Reset while in REPL_WR aborts the refill and clears everything.
    drive(RP, 6'd7, 6'h00, 1'b0, 4'b0, 32'h0, {16{32'h1111_2222}});
    check("abort_evict_valid", 512'(evict_valid), 512'(1));
    check("abort_evict_data", evict_data, pat_sw(0, 7));
    rst = 1'b1;
    #1;
    check("abort_evict_forced0", 512'(evict_valid), '0);
    check("abort_evict_data0", evict_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 512'(req_ready), 512'(1));
    drive(RD, 6'd7, 6'h00, 1'b0, 4'b0, 32'h0, '0);
    check("abort_no_refill", 512'(read_data), '0);
    drive(RD, 6'd40, 6'h3C, 1'b1, 4'b0, 32'h0, '0);
    check("abort_array_clear", 512'(read_data), '0);
    check("abort_rd_valid", 512'(rd_valid), 512'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
